// File: rtl/asynchronous_fifo_write_packer.sv
// rtl/asynchronous_fifo_write_packer.sv - packs narrow stream beats into wide FIFO words with a lane-valid mask
//
// Purpose: write-domain front end of the asynchronous FIFO. Accepts RATIO beats of
// INPUT_WIDTH bits (little-endian lane order) and emits one OUTPUT_WIDTH word plus a
// RATIO-bit lane mask per completed word. A word closes on the last lane or on
// input_last; unused lanes are filled with PAD_VALUE. write_flush drops partial and
// held words.
//
// Ports:
//   write_clock        write-domain clock
//   write_resetn       asynchronous active-low reset
//   write_flush        synchronous flush (shared with the FIFO write_flush)
//   input_valid        input beat valid
//   input_ready        input beat accepted when input_valid && input_ready
//   input_data         input beat payload
//   input_last         close the current word after this beat
//   fifo_write_full    FIFO full flag, used as backpressure
//   fifo_write_enable  write strobe to the FIFO
//   fifo_write_data    packed data word (driven by the hold stage)
//   fifo_write_mask    lane-valid mask; bit k set = lane k holds real data
//   partial_pending    assembly buffer holds at least one uncommitted beat

module asynchronous_fifo_write_packer #(
    parameter int INPUT_WIDTH  = 8,
    parameter int RATIO        = 4,
    parameter int RATIO_LOG2   = $clog2(RATIO),
    parameter int OUTPUT_WIDTH = INPUT_WIDTH * RATIO,
    parameter logic [INPUT_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                    write_clock,
    input  logic                    write_resetn,
    input  logic                    write_flush,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic [INPUT_WIDTH-1:0]  input_data,
    input  logic                    input_last,
    input  logic                    fifo_write_full,
    output logic                    fifo_write_enable,
    output logic [OUTPUT_WIDTH-1:0] fifo_write_data,
    output logic [RATIO-1:0]        fifo_write_mask,
    output logic                    partial_pending
);

    localparam int MASK_WIDTH = RATIO;
    localparam logic [OUTPUT_WIDTH-1:0] PAD_WORD = {RATIO{PAD_VALUE}};
    localparam logic [RATIO_LOG2-1:0]   LAST_LANE = RATIO_LOG2'(RATIO - 1);

    // Assembly buffer
    logic [OUTPUT_WIDTH-1:0] assembly_data;
    logic [MASK_WIDTH-1:0]   assembly_mask;
    logic [RATIO_LOG2-1:0]   lane;

    // One-entry hold stage feeding the FIFO
    logic                    hold_valid;
    logic [OUTPUT_WIDTH-1:0] hold_data;
    logic [MASK_WIDTH-1:0]   hold_mask;

    logic                    accept;
    logic                    complete;
    logic [OUTPUT_WIDTH-1:0] merged_data;
    logic [MASK_WIDTH-1:0]   merged_mask;

    assign fifo_write_enable = hold_valid && !fifo_write_full && !write_flush;
    // Conservative: the hold stage must be empty or draining this cycle before a
    // new beat is taken, so a completing beat always has somewhere to land.
    assign input_ready       = !write_flush && (!hold_valid || fifo_write_enable);
    assign accept            = input_valid && input_ready;
    assign complete          = accept && ((lane == LAST_LANE) || input_last);

    assign fifo_write_data   = hold_data;
    assign fifo_write_mask   = hold_mask;

    // Current beat merged into the assembly buffer; becomes either the new
    // assembly state or, on completion, the word loaded into the hold stage.
    always_comb begin
        merged_data = assembly_data;
        merged_data[lane*INPUT_WIDTH +: INPUT_WIDTH] = input_data;
        merged_mask = assembly_mask | (MASK_WIDTH'(1) << lane);
    end

    always_ff @(posedge write_clock or negedge write_resetn) begin
        if (!write_resetn) begin
            assembly_data   <= PAD_WORD;
            assembly_mask   <= '0;
            lane            <= '0;
            partial_pending <= 1'b0;
            hold_valid      <= 1'b0;
            hold_data       <= '0;
            hold_mask       <= '0;
        end else if (write_flush) begin
            assembly_data   <= PAD_WORD;
            assembly_mask   <= '0;
            lane            <= '0;
            partial_pending <= 1'b0;
            hold_valid      <= 1'b0;
            hold_data       <= '0;
            hold_mask       <= '0;
        end else begin
            if (fifo_write_enable) begin
                hold_valid <= 1'b0;
            end
            if (accept) begin
                if (complete) begin
                    // Reload wins over the drain above when both happen together.
                    hold_valid      <= 1'b1;
                    hold_data       <= merged_data;
                    hold_mask       <= merged_mask;
                    assembly_data   <= PAD_WORD;
                    assembly_mask   <= '0;
                    lane            <= '0;
                    partial_pending <= 1'b0;
                end else begin
                    assembly_data   <= merged_data;
                    assembly_mask   <= merged_mask;
                    lane            <= lane + RATIO_LOG2'(1);
                    partial_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/asynchronous_fifo_write_packer.md
Name: asynchronous_fifo_write_packer

Overview:
Write-domain front end of the asynchronous advanced FIFO. It accepts a narrow valid/ready stream with a last marker and packs RATIO beats into one wide FIFO word plus a lane-valid mask. It drives the FIFO controller's write_enable/write_data and uses its write_full flag as backpressure. Partial words are emitted on input_last, padded with PAD_VALUE. Write flush discards any partially assembled word.

Parameters:
INPUT_WIDTH, 8, width of one input beat
RATIO, 4, beats per FIFO word (≥2; any integer, not only powers of 2)
RATIO_LOG2, `CLOG2(RATIO), lane counter width
OUTPUT_WIDTH, INPUT_WIDTH*RATIO, FIFO word data width
PAD_VALUE, 0, INPUT_WIDTH-bit fill value for unused lanes

Ports:
write_clock  in  1  write-domain clock
write_resetn  in  1  asynchronous active-low reset, write domain
write_flush  in  1  synchronous flush, tied to the FIFO write_flush
input_valid  in  1  input beat valid
input_ready  out  1  input beat accepted when valid&&ready
input_data  in  INPUT_WIDTH  input beat payload
input_last  in  1  close the current word after this beat
fifo_write_full  in  1  FIFO write_full flag
fifo_write_enable  out  1  write strobe to FIFO write_enable
fifo_write_data  out  OUTPUT_WIDTH  packed data word
fifo_write_mask  out  RATIO  lane-valid mask; bit k set = lane k holds real data
partial_pending  out  1  assembly buffer holds ≥1 uncommitted beat

Behaviour:
- Reset is write_resetn, asynchronous, active-low. Clock is write_clock. Reset clears the lane counter, assembly data/mask and hold stage. Outputs after reset: fifo_write_enable=0, fifo_write_data=0, fifo_write_mask=0, partial_pending=0, input_ready=1.
- Storage:
  - Assembly buffer: data, mask, lane counter 0..RATIO-1.
  - One-entry hold stage: valid, data, mask. The hold stage drives fifo_write_data/mask directly.
- Lane order is little-endian: the beat at lane k is written to data[k*INPUT_WIDTH +: INPUT_WIDTH] and sets mask[k].
- accept = input_valid && input_ready. On accept the lane counter increments. If the beat completes the word, the counter returns to 0.
- A word completes on accept when lane==RATIO-1 or input_last=1. At the same edge, the completed word (including the current beat) loads into the hold stage. The assembly buffer resets to PAD_VALUE in all lanes, mask 0.
- fifo_write_enable = hold_valid && !fifo_write_full && !write_flush (combinational). The hold stage empties on that cycle unless it is reloaded in the same cycle.
- input_ready = !write_flush && (!hold_valid || fifo_write_enable). This is conservative: any beat stalls while the hold stage is occupied and not draining.
- Latency: a completing beat accepted at edge N gives fifo_write_enable=1 in the cycle after N if the FIFO is not full.
- Throughput: one beat per cycle, one word per RATIO cycles, sustained while the FIFO is not full.
- Full: the hold stage keeps its data and mask stable, and fifo_write_enable stays 0. Once the hold stage is occupied, input_ready=0 until it drains. No data is lost and no FIFO write_miss is generated.
- input_last with lane 0: emits a word with mask=1 (single lane) and other lanes at PAD_VALUE.
- Flush:
  - While write_flush=1, input_ready=0 and fifo_write_enable=0.
  - At the edge it clears the hold stage, assembly buffer, mask and lane counter. Partial and held words are discarded.
  - Flush has priority over every other event.
- partial_pending = (lane counter != 0), registered state.
- Reset mid-word discards all state; the FIFO is reset independently.

Decomposition:
- No shared package. Only the `CLOG2` include and localparams are needed: lane mask width, and PAD_VALUE replicated to OUTPUT_WIDTH for the assembly reset value.
- Single flat module. The hold stage is too small to justify a sub-module.
- Instantiated beside asynchronous_advanced_fifo_controller, whose WIDTH = OUTPUT_WIDTH + RATIO (data plus mask).

Test Plan:
- Reset released, stream 0x11,0x22,0x33,0x44 on consecutive cycles, full=0 → one fifo_write_enable pulse, data=0x44332211, mask=4'b1111, one cycle after the 4th accept.
- Beats 0xAA,0xBB with last on 0xBB, PAD_VALUE=0 → data=0x0000BBAA, mask=4'b0011; partial_pending=0 afterwards.
- Complete word 0x04030201 while fifo_write_full=1 for 5 cycles, input continues → enable stays 0, data held, input_ready=0; word written in the first cycle full drops; no beat lost.
- Beats 0x01,0x02 then write_flush one cycle, then 0x10,0x20,0x30,0x40 → no write for the flushed beats; next write data=0x40302010, mask=1111.
- Single beat 0x5A with last at lane 0 → data=0x0000005A, mask=4'b0001.
- 64 random beats with random last and random full, scoreboard on unpacked lanes → FIFO contents match input order exactly; input_ready never high during flush.
